// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin share of one line-based memory port between the
//            icache refill path and the dcache refill/writeback path.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_valid,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_req_ready,
    output logic              ic_resp_valid,
    input  logic              dc_req_valid,
    input  logic              dc_req_rw,
    input  logic [ADDR_W-1:0] dc_req_addr,
    output logic              dc_req_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rw,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic              err
);

    localparam int c_cnt_w = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADDR  = 2'd1,
        S_WDATA = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_owner;       // 1 = dcache owns the transaction
    logic                r_rw;
    logic                r_last_grant;  // 1 = dcache was granted last
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_cnt_w-1:0]  r_cnt;

    logic w_ic_win;
    logic w_dc_win;
    logic w_accept;
    logic w_beat;

    // On a tie the side that was not granted last time wins.
    assign w_ic_win = ic_req_valid && (!dc_req_valid || r_last_grant);
    assign w_dc_win = dc_req_valid && (!ic_req_valid || !r_last_grant);
    assign w_accept = (r_state == S_IDLE) && (w_ic_win || w_dc_win);

    always_comb begin
        w_state_next    = r_state;
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        ic_resp_valid   = 1'b0;
        dc_resp_valid   = 1'b0;
        resp_last       = 1'b0;
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        dc_wdata_ready  = 1'b0;
        w_beat          = 1'b0;
        case (r_state)
            S_IDLE: begin
                ic_req_ready = w_ic_win;
                dc_req_ready = w_dc_win;
                if (w_accept)
                    w_state_next = S_ADDR;
            end
            S_ADDR: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)
                    w_state_next = r_rw ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                dc_wdata_ready  = mem_wdata_ready;
                w_beat          = dc_wdata_valid && mem_wdata_ready;
                if (w_beat && (r_cnt == c_last_beat)) begin
                    dc_resp_valid = 1'b1;
                    resp_last     = 1'b1;
                    w_state_next  = S_IDLE;
                end
            end
            S_RDATA: begin
                if (mem_resp_valid) begin
                    w_beat        = 1'b1;
                    ic_resp_valid = !r_owner;
                    dc_resp_valid = r_owner;
                    if (r_cnt == c_last_beat) begin
                        resp_last    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_rw         <= 1'b0;
            r_last_grant <= 1'b0;
            r_err        <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_owner      <= w_dc_win;
                r_last_grant <= w_dc_win;
                r_rw         <= w_dc_win && dc_req_rw;
                r_addr       <= w_dc_win ? dc_req_addr : ic_req_addr;
            end
            // Counter wraps naturally to zero on the final beat.
            if ((r_state == S_ADDR) && mem_req_ready)
                r_cnt <= '0;
            else if (w_beat)
                r_cnt <= r_cnt + c_cnt_w'(1);
            if (mem_resp_valid && (r_state != S_RDATA))
                r_err <= 1'b1;
        end
    end

    assign mem_req_rw   = r_rw;
    assign mem_req_addr = r_addr;
    assign mem_wdata    = dc_wdata;
    assign resp_data    = mem_resp_data;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              ic_req_valid;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_req_ready;
    logic              ic_resp_valid;
    logic              dc_req_valid;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic              dc_req_ready;
    logic [DATA_W-1:0] dc_wdata;
    logic              dc_wdata_valid;
    logic              dc_wdata_ready;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_last;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    bit m_last_d;   // model: last grant went to dcache

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
        .ic_req_ready(ic_req_ready), .ic_resp_valid(ic_resp_valid),
        .dc_req_valid(dc_req_valid), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_req_ready(dc_req_ready),
        .dc_wdata(dc_wdata), .dc_wdata_valid(dc_wdata_valid),
        .dc_wdata_ready(dc_wdata_ready), .dc_resp_valid(dc_resp_valid),
        .resp_data(resp_data), .resp_last(resp_last),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_wdata(mem_wdata), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .err(err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Vector: ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
    //         resp_last, mem_req_valid, mem_wdata_valid, dc_wdata_ready
    task automatic check_outs(input string tag, input logic [7:0] exp);
        check(tag, {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid,
                    resp_last, mem_req_valid, mem_wdata_valid, dc_wdata_ready}, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_inputs();
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
        dc_wdata = '0; dc_wdata_valid = 0;
        mem_req_ready = 0; mem_wdata_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        clear_inputs();
        repeat (n) step();
        reset = 0;
        m_last_d = 0;
        @(negedge clk);
        check_outs("reset_outs", 8'h00);
        check("reset_err", err, 0);
        step();
    endtask

    // Runs one transaction from the current request pattern. Entry and exit
    // are one time unit after a rising edge with the DUT expected idle.
    task automatic run_txn(input int stall, input int abort_after, input bit dense,
                           output bit won_d);
        logic [ADDR_W-1:0] a;
        logic [127:0]      d;
        bit                rw, hs, beat, last;
        int                k, guard;
        won_d = (ic_req_valid && dc_req_valid) ? !m_last_d : dc_req_valid;
        a     = won_d ? dc_req_addr : ic_req_addr;
        rw    = won_d && dc_req_rw;
        @(negedge clk);
        check_outs("accept", {!won_d, won_d, 6'b0});
        m_last_d = won_d;
        step();
        if (won_d) dc_req_valid = 0; else ic_req_valid = 0;
        for (int c = 0; c <= stall; c++) begin
            mem_req_ready = (c == stall);
            @(negedge clk);
            check_outs("addr_phase", 8'b0000_0100);
            check("mem_req_addr", mem_req_addr, a);
            check("mem_req_rw", mem_req_rw, rw);
            step();
        end
        mem_req_ready = 0;
        k = 0;
        guard = 0;
        while (k < BEATS && guard < 200) begin
            d = rand128();
            if (rw) begin
                dc_wdata        = d;
                dc_wdata_valid  = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
                mem_wdata_ready = dense ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
                hs   = dc_wdata_valid && mem_wdata_ready;
                last = hs && (k == BEATS - 1);
                @(negedge clk);
                check_outs("wbeat", {3'b000, last, last, 1'b0, dc_wdata_valid, mem_wdata_ready});
                if (dc_wdata_valid) check("mem_wdata", mem_wdata, d);
            end else begin
                beat           = dense ? 1'b1 : ($urandom_range(0, 2) != 0);
                mem_resp_valid = beat;
                mem_resp_data  = d;
                hs   = beat;
                last = beat && (k == BEATS - 1);
                @(negedge clk);
                check_outs("rbeat", {2'b00, beat && !won_d, beat && won_d, last, 3'b000});
                if (beat) check("resp_data", resp_data, d);
            end
            if (hs) k++;
            guard++;
            step();
            if (!rw && abort_after >= 0 && k == abort_after) begin
                mem_resp_valid = 0;
                do_reset(1);
                return;
            end
        end
        mem_resp_valid  = 0;
        dc_wdata_valid  = 0;
        mem_wdata_ready = 0;
        if (k < BEATS) check("beat_budget", k, BEATS);
    endtask

    initial begin
        bit won;
        reset = 1;
        clear_inputs();
        do_reset(3);

        // Directed icache read of 0x40 with back-to-back beats.
        ic_req_valid = 1; ic_req_addr = 32'h40;
        run_txn(0, -1, 1, won);
        check("ic_read_owner", won, 0);

        // Tie-break order after reset: D, I, D, I.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            ic_req_valid = 1; ic_req_addr = 32'h1000 + 32'(i) * 32'h40;
            dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h2000 + 32'(i) * 32'h40;
            run_txn(0, -1, 1, won);
            check("grant_order", won, (i % 2 == 0));
        end
        ic_req_valid = 0; dc_req_valid = 0;

        // dcache write of 0x100 with memory ready toggling.
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h100;
        run_txn(0, -1, 1, won);
        @(negedge clk);
        check_outs("idle_after_write", 8'h00);
        step();

        // Address phase held for 10 cycles.
        ic_req_valid = 1; ic_req_addr = 32'h880;
        run_txn(10, -1, 0, won);

        // Reset mid-read after two beats, then a fresh read.
        ic_req_valid = 1; ic_req_addr = 32'hC0;
        run_txn(0, 2, 1, won);
        ic_req_valid = 1; ic_req_addr = 32'h140;
        run_txn(0, -1, 1, won);
        check("err_clean", err, 0);

        // Stray memory beat while idle sets a sticky error.
        mem_resp_valid = 1; mem_resp_data = rand128();
        @(negedge clk);
        check_outs("stray_quiet", 8'h00);
        step();
        mem_resp_valid = 0;
        @(negedge clk);
        check("err_set", err, 1);
        repeat (3) step();
        @(negedge clk);
        check("err_sticky", err, 1);
        step();
        do_reset(2);

        // Randomized traffic; a pending loser keeps its request untouched.
        for (int t = 0; t < 30; t++) begin
            if (!ic_req_valid && ($urandom_range(0, 1) != 0)) begin
                ic_req_valid = 1;
                ic_req_addr  = $urandom & 32'hFFFF_FFC0;
            end
            if (!dc_req_valid && ($urandom_range(0, 1) != 0)) begin
                dc_req_valid = 1;
                dc_req_rw    = 1'($urandom_range(0, 1));
                dc_req_addr  = $urandom & 32'hFFFF_FFC0;
            end
            if (!ic_req_valid && !dc_req_valid) begin
                ic_req_valid = 1;
                ic_req_addr  = $urandom & 32'hFFFF_FFC0;
            end
            run_txn($urandom_range(0, 3), -1, 0, won);
            check("err_clean_rand", err, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the processor's single backing-memory port between the instruction-cache refill path and the data-cache refill/writeback path. It sits between the two cache controllers and external memory. It accepts one line-sized transaction at a time from either side, with round-robin arbitration when both request together. It sequences the address phase, BEATS data beats and completion, and routes read beats back to the owning requester.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 128, beat width
- BEATS, 4, beats per line transaction (≥2, power of two)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ic_req_valid  in  1  icache read request
- ic_req_addr  in  ADDR_W  icache line address
- ic_req_ready  out  1  icache request accepted this cycle
- ic_resp_valid  out  1  icache read beat valid
- dc_req_valid  in  1  dcache request
- dc_req_rw  in  1  1 = write, 0 = read
- dc_req_addr  in  ADDR_W  dcache line address
- dc_req_ready  out  1  dcache request accepted this cycle
- dc_wdata  in  DATA_W  write beat from dcache
- dc_wdata_valid  in  1  write beat valid
- dc_wdata_ready  out  1  write beat consumed
- dc_resp_valid  out  1  dcache read beat, or write ack
- resp_data  out  DATA_W  shared read-beat data
- resp_last  out  1  final beat / write ack
- mem_req_valid  out  1  memory address phase
- mem_req_ready  in  1  memory accepts address
- mem_req_rw  out  1  registered rw
- mem_req_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  write beat to memory
- mem_wdata_valid  out  1  write beat valid
- mem_wdata_ready  in  1  memory accepts beat
- mem_resp_valid  in  1  read beat from memory
- mem_resp_data  in  DATA_W  read beat data
- err  out  1  sticky: mem_resp_valid seen outside RDATA

## Operation
- States: IDLE, ADDR, WDATA, RDATA. Registers: owner (I/D), rw, addr, beat counter (log2 BEATS bits), last_grant, err.
- IDLE arbitration:
  - One requester valid: it wins.
  - Both valid: the requester not equal to last_grant wins.
  - Winner's req_ready = 1 combinationally. Latch owner, addr and rw. ic requests have rw = 0. Set last_grant = winner. Go to ADDR.
- ADDR: mem_req_valid = 1 with registered addr/rw, held stable until mem_req_ready. On handshake, rw goes to WDATA, otherwise to RDATA. Clear the counter.
- WDATA: mem_wdata = dc_wdata, mem_wdata_valid = dc_wdata_valid, dc_wdata_ready = mem_wdata_ready, all combinational. Each valid&ready handshake increments the counter. On the BEATS-th handshake, dc_resp_valid = 1 and resp_last = 1 in the same cycle, then go to IDLE.
- RDATA:
  - Each mem_resp_valid pulses the owner's resp_valid; resp_data = mem_resp_data.
  - Increment the counter. On the BEATS-th beat, resp_last = 1 and go to IDLE.
  - The non-owner's resp_valid stays 0.
- Requesters cannot backpressure read beats.
- dc_wdata_ready = 0 and mem_wdata_valid = 0 outside WDATA.
- mem_resp_valid outside RDATA is dropped and sets err. err is cleared only by reset.
- Counter wraps to 0 at transaction end. No beat is carried across transactions.
- req_ready is never asserted outside IDLE. A requester whose valid arrives mid-transaction waits.

## Timing
- Reset values:
  - State IDLE, counter 0, last_grant = I (so D wins the first tie), err 0.
  - All req_ready/resp_valid/resp_last/mem_*_valid/dc_wdata_ready are 0 in the cycle after reset, except req_ready, which is combinational in IDLE.
  - mem_req_addr, mem_req_rw and resp_data are don't-care.
- Reset mid-transaction returns to IDLE next cycle and abandons the in-flight memory transaction. Memory is reset by the same signal.
- Request accepted in cycle T: mem_req_valid first high at T+1.
- Read beats to the requester have 0 added latency: same cycle as mem_resp_valid.
- The final beat/ack cycle moves to IDLE. The earliest next acceptance is the following cycle (1-cycle gap), and arbitration is re-evaluated there.
- Beats may arrive in the ADDR-handshake cycle's successor at the earliest. Beats in the same cycle as the address handshake set err.

## Test plan
- Reset 3 cycles, no requests → all valid/ready outputs 0 except ic/dc_req_ready 0 (no request), err 0.
- ic read 0x40, mem_req_ready immediate, beats A0..A3 on consecutive cycles → mem_req_addr 0x40 at T+1, ic_resp_valid 4 cycles with resp_data A0..A3, resp_last only with A3, dc_resp_valid 0 throughout.
- ic and dc both request after reset, then both again after each completion → grant order D, I, D, I. Each loser holds until granted.
- dc write 0x100, beats W0..W3, mem_wdata_ready toggling 1/0 → exactly 4 beats forwarded in order. dc_resp_valid & resp_last on the 4th handshake only. Back in IDLE the next cycle.
- mem_req_ready low 10 cycles → mem_req_valid, addr and rw stable for all 10 cycles. Counter stays 0 and no resp_valid.
- Reset after 2 of 4 read beats, then a new ic read → IDLE, fresh 4-beat count, resp_last on the 4th new beat. A stray mem_resp_valid in IDLE sets err = 1, which stays set until the next reset.
